// File: rtl/slice_cfg_writer_pkg.sv
// Shared types, constants and CRC step function for the slice configuration writer.
// Latency: n/a (package only).
// Backpressure: n/a.
package slice_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_TRAIL  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam int          CFG_WORD_W = 16;
    localparam logic [15:0] CRC_POLY   = 16'h1021;
    localparam logic [15:0] CRC_INIT   = 16'hFFFF;

    // One MSB-first CRC-16-CCITT step (no reflection, no final XOR).
    function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic b_in);
        logic fb;
        fb = crc[15] ^ b_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/slice_cfg_writer_if.sv
// Word-input / serial-chain bundle between the config controller and the writer.
// Latency: n/a (wires only).
// Backpressure: din_valid/din_ready handshake; the chain side has no backpressure.
// master: controller side (drives din/din_valid/din_last); slave: writer side.
interface slice_cfg_writer_if;
    import slice_cfg_pkg::*;

    logic [CFG_WORD_W-1:0] din;
    logic                  din_valid;
    logic                  din_last;
    logic                  din_ready;
    logic                  cfg_sdo;
    logic                  cfg_sen;
    logic                  cfg_update;
    logic                  busy;
    logic                  err;

    modport master (
        output din, din_valid, din_last,
        input  din_ready, cfg_sdo, cfg_sen, cfg_update, busy, err
    );

    modport slave (
        input  din, din_valid, din_last,
        output din_ready, cfg_sdo, cfg_sen, cfg_update, busy, err
    );

endinterface

// File: rtl/slice_cfg_writer_crc16.sv
// Bit-serial CRC-16-CCITT register with synchronous clear and enable.
// Latency: each enabled bit is folded in at the clock edge; o_crc is registered.
// Backpressure: none (follows i_en).
// Ports: i_clk, i_rst_n, i_clr (reload init), i_en (absorb i_bit), i_bit, o_crc.
module slice_cfg_crc16
    import slice_cfg_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= CRC_INIT;
        end else if (i_clr) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= crc16_bit(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/slice_cfg_writer.sv
// Shifts 16-bit LUT words MSB-first onto the slice chain and commits each frame with one update pulse.
// Latency: word accepted in cycle t drives cfg_sdo in t+1..t+16; update in t_last+17 (CRC build: trailer accept +1).
// Backpressure: din_ready only in IDLE, on a word's final bit, while stalled, and in TRAIL; a missing word stalls the chain.
// Ports: i_clk, i_rst_n (async active-low), io_bus (slave modport: din/din_valid/din_last/din_ready,
//        cfg_sdo/cfg_sen/cfg_update, busy, err). Parameter N_WORDS = words per frame (1..256).
// Build option: define SLICE_CFG_CRC_EN to add the CRC trailer word check (TRAIL state).
module slice_cfg_writer
    import slice_cfg_pkg::*;
#(
    parameter int N_WORDS = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    slice_cfg_writer_if.slave  io_bus
);

    localparam int              CNT_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

    state_t                r_state;
    logic [CFG_WORD_W-1:0] r_sreg;
    logic [3:0]            r_bitcnt;     // index of the bit currently on cfg_sdo
    logic [CNT_W-1:0]      r_wordcnt;
    logic                  r_last_flag;  // current word carried din_last
    logic                  r_ready;
    logic                  r_sdo;
    logic                  r_sen;
    logic                  r_update;
    logic                  r_busy;
    logic                  r_err;

    logic w_accept;
    logic w_final;
    logic w_len_err;

    assign w_accept  = io_bus.din_valid & r_ready;
    // The current word ends the frame either by its LAST flag or by filling the chain.
    assign w_final   = r_last_flag | (r_wordcnt == LAST_IDX);
    assign w_len_err = (r_wordcnt != LAST_IDX) | ~r_last_flag;

`ifdef SLICE_CFG_CRC_EN
    logic [15:0] w_crc;
    logic        w_crc_bad;

    // Cleared throughout IDLE; absorbs exactly the bits driven with cfg_sen high.
    slice_cfg_crc16 u_crc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (r_state == ST_IDLE),
        .i_en    (r_sen),
        .i_bit   (r_sdo),
        .o_crc   (w_crc)
    );

    assign w_crc_bad = (io_bus.din != w_crc);
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_sreg      <= '0;
            r_bitcnt    <= '0;
            r_wordcnt   <= '0;
            r_last_flag <= 1'b0;
            r_ready     <= 1'b0;
            r_sdo       <= 1'b0;
            r_sen       <= 1'b0;
            r_update    <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_update <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_sdo       <= io_bus.din[CFG_WORD_W-1];
                        r_sreg      <= {io_bus.din[CFG_WORD_W-2:0], 1'b0};
                        r_bitcnt    <= '0;
                        r_sen       <= 1'b1;
                        r_ready     <= 1'b0;
                        r_last_flag <= io_bus.din_last;
                        r_wordcnt   <= '0;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (r_sen && (r_bitcnt != 4'd15)) begin
                        r_sdo    <= r_sreg[CFG_WORD_W-1];
                        r_sreg   <= {r_sreg[CFG_WORD_W-2:0], 1'b0};
                        r_bitcnt <= r_bitcnt + 4'd1;
                        // Open the input for the final bit only if another word belongs to this frame.
                        r_ready  <= (r_bitcnt == 4'd14) & ~w_final;
                    end else if (w_accept) begin
                        // r_ready is never raised on a final word, so this is always a continuation.
                        r_sdo       <= io_bus.din[CFG_WORD_W-1];
                        r_sreg      <= {io_bus.din[CFG_WORD_W-2:0], 1'b0};
                        r_bitcnt    <= '0;
                        r_sen       <= 1'b1;
                        r_ready     <= 1'b0;
                        r_last_flag <= io_bus.din_last;
                        r_wordcnt   <= r_wordcnt + 1'b1;
                    end else if (w_final) begin
                        r_sen <= 1'b0;
                        r_sdo <= 1'b0;
                        r_err <= w_len_err;
`ifdef SLICE_CFG_CRC_EN
                        r_ready <= 1'b1;
                        r_state <= ST_TRAIL;
`else
                        r_ready  <= 1'b0;
                        r_update <= ~w_len_err;
                        r_state  <= ST_COMMIT;
`endif
                    end else begin
                        // Stall: chain idles, input stays open until the next word shows up.
                        r_sen <= 1'b0;
                        r_sdo <= 1'b0;
                    end
                end

`ifdef SLICE_CFG_CRC_EN
                ST_TRAIL: begin
                    // Trailer is compared, never shifted; its LAST flag is irrelevant.
                    if (w_accept) begin
                        r_ready  <= 1'b0;
                        r_err    <= r_err | w_crc_bad;
                        r_update <= ~(r_err | w_crc_bad);
                        r_state  <= ST_COMMIT;
                    end
                end
`endif

                ST_COMMIT: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_bus.din_ready  = r_ready;
    assign io_bus.cfg_sdo    = r_sdo;
    assign io_bus.cfg_sen    = r_sen;
    assign io_bus.cfg_update = r_update;
    assign io_bus.busy       = r_busy;
    assign io_bus.err        = r_err;

endmodule
